max7219_refresh_scanner: RTL and testbench



---
 rtl/max7219_pkg.sv | 30 +++
 rtl/max7219_refresh_scanner_if.sv | 32 +++
 rtl/max7219_bit_timer.sv | 37 +++
 rtl/max7219_refresh_scanner.sv | 149 ++++++++++++++
 tb/tb_max7219_refresh_scanner.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 refresh scanner: register map, init words,
// FSM state encodings and command-list indices.
package max7219_pkg;

    localparam logic [3:0] RegDigit0    = 4'h1;
    localparam logic [3:0] RegDecode    = 4'h9;
    localparam logic [3:0] RegIntensity = 4'hA;
    localparam logic [3:0] RegScanLimit = 4'hB;
    localparam logic [3:0] RegShutdown  = 4'hC;
    localparam logic [3:0] RegTest      = 4'hF;

    localparam logic [15:0] InitShutdown  = {4'h0, RegShutdown, 8'h01};
    localparam logic [15:0] InitDecode    = {4'h0, RegDecode, 8'h00};
    localparam logic [15:0] InitScanLimit = {4'h0, RegScanLimit, 8'h07};
    localparam logic [15:0] InitTest      = {4'h0, RegTest, 8'h00};

    localparam logic [3:0] LoopStart = 4'd4;
    localparam logic [3:0] LastCmd   = 4'd12;

    localparam logic [1:0] StLoad  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StLatch = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    function automatic logic [15:0] make_frame(input logic [3:0] reg_addr,
                                               input logic [7:0] data);
        return {4'h0, reg_addr, data};
    endfunction

endpackage

// File: rtl/max7219_refresh_scanner_if.sv
// Bundle between the scanner, the upstream row mux and the matrix pins.
interface max7219_refresh_scanner_if;

    logic [7:0] SC_MAX7219SCAN_data_InBUS;
    logic [3:0] SC_MAX7219SCAN_intensity_InBUS;
    logic [2:0] SC_MAX7219SCAN_addr_OutBUS;
    logic       SC_MAX7219SCAN_DIN_Out;
    logic       SC_MAX7219SCAN_NCS_Out;
    logic       SC_MAX7219SCAN_CLK_Out;
    logic       SC_MAX7219SCAN_frameDone_Out;

    modport master (
        input  SC_MAX7219SCAN_data_InBUS,
        input  SC_MAX7219SCAN_intensity_InBUS,
        output SC_MAX7219SCAN_addr_OutBUS,
        output SC_MAX7219SCAN_DIN_Out,
        output SC_MAX7219SCAN_NCS_Out,
        output SC_MAX7219SCAN_CLK_Out,
        output SC_MAX7219SCAN_frameDone_Out
    );

    modport slave (
        output SC_MAX7219SCAN_data_InBUS,
        output SC_MAX7219SCAN_intensity_InBUS,
        input  SC_MAX7219SCAN_addr_OutBUS,
        input  SC_MAX7219SCAN_DIN_Out,
        input  SC_MAX7219SCAN_NCS_Out,
        input  SC_MAX7219SCAN_CLK_Out,
        input  SC_MAX7219SCAN_frameDone_Out
    );

endinterface

// File: rtl/max7219_bit_timer.sv
// Half-period timer: strobes phase_end every CLKDIV_HALF cycles and flips
// toggle on each strobe; restart realigns both to the start of a low phase.
module max7219_bit_timer #(
    parameter int unsigned CLKDIV_HALF = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_end,
    output logic toggle
);

    localparam logic [CNT_WIDTH-1:0] Last = CNT_WIDTH'(CLKDIV_HALF - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 toggle_q;

    assign phase_end = (cnt_q == Last);
    assign toggle    = toggle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            toggle_q <= 1'b0;
        end else if (restart) begin
            cnt_q    <= '0;
            toggle_q <= 1'b0;
        end else if (phase_end) begin
            cnt_q    <= '0;
            toggle_q <= ~toggle_q;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/max7219_refresh_scanner.sv
// MAX7219 front end: sends the init sequence once after reset, then loops
// rewriting intensity and digits 1..8 as 16-bit serial frames.
module max7219_refresh_scanner
    import max7219_pkg::*;
#(
    parameter int unsigned CLKDIV_HALF = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input logic                          SC_MAX7219SCAN_CLOCK_50,
    input logic                          SC_MAX7219SCAN_RESET_InLow,
    max7219_refresh_scanner_if.master    bus
);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cmd_idx_q, cmd_idx_d;
    logic        init_pending_q, init_pending_d;
    logic [14:0] shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        din_q, din_d;
    logic        ncs_q, ncs_d;
    logic        sclk_q, sclk_d;
    logic [2:0]  addr_q, addr_d;
    logic        frame_done_q, frame_done_d;

    logic        timer_restart;
    logic        phase_end;
    logic        toggle;
    logic [15:0] frame;

    max7219_bit_timer #(
        .CLKDIV_HALF (CLKDIV_HALF),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_bit_timer (
        .clk       (SC_MAX7219SCAN_CLOCK_50),
        .rst_n     (SC_MAX7219SCAN_RESET_InLow),
        .restart   (timer_restart),
        .phase_end (phase_end),
        .toggle    (toggle)
    );

    // Command ROM; indices 5..12 are digit rows addressed by addr_q.
    always_comb begin
        frame = make_frame(RegDigit0 + {1'b0, addr_q}, bus.SC_MAX7219SCAN_data_InBUS);
        case (cmd_idx_q)
            4'd0:    frame = InitShutdown;
            4'd1:    frame = InitDecode;
            4'd2:    frame = InitScanLimit;
            4'd3:    frame = InitTest;
            4'd4:    frame = make_frame(RegIntensity, {4'h0, bus.SC_MAX7219SCAN_intensity_InBUS});
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cmd_idx_d      = cmd_idx_q;
        init_pending_d = init_pending_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        din_d          = din_q;
        ncs_d          = ncs_q;
        sclk_d         = sclk_q;
        addr_d         = addr_q;
        frame_done_d   = 1'b0;
        timer_restart  = 1'b0;

        case (state_q)
            StLoad: begin
                timer_restart = 1'b1;
                shreg_d       = frame[14:0];
                din_d         = frame[15];
                sclk_d        = 1'b0;
                bit_cnt_d     = 4'd0;
                state_d       = StShift;
            end
            StShift: begin
                if (phase_end) begin
                    if (!toggle) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 4'd15) begin
                            state_d = StLatch;
                        end else begin
                            din_d     = shreg_q[14];
                            shreg_d   = {shreg_q[13:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            StLatch: begin
                if (phase_end) begin
                    ncs_d   = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (phase_end) begin
                    ncs_d          = 1'b0;
                    state_d        = StLoad;
                    init_pending_d = 1'b0;
                    // The GAP that follows reset precedes command 0, so nothing advances.
                    if (!init_pending_q) begin
                        cmd_idx_d    = (cmd_idx_q == LastCmd) ? LoopStart : cmd_idx_q + 4'd1;
                        frame_done_d = (cmd_idx_q == LastCmd);
                        if (cmd_idx_q > LoopStart) begin
                            addr_d = addr_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = StGap;
        endcase
    end

    always_ff @(posedge SC_MAX7219SCAN_CLOCK_50) begin
        if (!SC_MAX7219SCAN_RESET_InLow) begin
            state_q        <= StGap;
            cmd_idx_q      <= 4'd0;
            init_pending_q <= 1'b1;
            shreg_q        <= '0;
            bit_cnt_q      <= 4'd0;
            din_q          <= 1'b0;
            ncs_q          <= 1'b1;
            sclk_q         <= 1'b0;
            addr_q         <= 3'd0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_idx_q      <= cmd_idx_d;
            init_pending_q <= init_pending_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            din_q          <= din_d;
            ncs_q          <= ncs_d;
            sclk_q         <= sclk_d;
            addr_q         <= addr_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.SC_MAX7219SCAN_addr_OutBUS   = addr_q;
    assign bus.SC_MAX7219SCAN_DIN_Out       = din_q;
    assign bus.SC_MAX7219SCAN_NCS_Out       = ncs_q;
    assign bus.SC_MAX7219SCAN_CLK_Out       = sclk_q;
    assign bus.SC_MAX7219SCAN_frameDone_Out = frame_done_q;

endmodule

// File: tb/tb_max7219_refresh_scanner.sv
// Bench: two scanners (H=4 and H=1) feeding pin-level frame decoders, checked
// against a table of expected frames plus reset/timing corner sequences.
module tb_max7219_refresh_scanner;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] int_a;
    logic       ovr_en;
    logic [7:0] ovr_val;
    logic       mon_on;

    max7219_refresh_scanner_if bus_a ();
    max7219_refresh_scanner_if bus_b ();

    max7219_refresh_scanner #(.CLKDIV_HALF(4), .CNT_WIDTH(8)) dut_a (
        .SC_MAX7219SCAN_CLOCK_50    (clk),
        .SC_MAX7219SCAN_RESET_InLow (rst_a),
        .bus                        (bus_a)
    );

    max7219_refresh_scanner #(.CLKDIV_HALF(1), .CNT_WIDTH(8)) dut_b (
        .SC_MAX7219SCAN_CLOCK_50    (clk),
        .SC_MAX7219SCAN_RESET_InLow (rst_b),
        .bus                        (bus_b)
    );

    // Row-mux model: one lit column per row, optionally overridden on A.
    assign bus_a.SC_MAX7219SCAN_data_InBUS =
        ovr_en ? ovr_val : (8'h80 >> bus_a.SC_MAX7219SCAN_addr_OutBUS);
    assign bus_a.SC_MAX7219SCAN_intensity_InBUS = int_a;
    assign bus_b.SC_MAX7219SCAN_data_InBUS = 8'h80 >> bus_b.SC_MAX7219SCAN_addr_OutBUS;
    assign bus_b.SC_MAX7219SCAN_intensity_InBUS = 4'hA;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level decoder state, index 0 = A, 1 = B.
    logic        prev_clk [2] = '{1'b0, 1'b0};
    logic        prev_ncs [2] = '{1'b1, 1'b1};
    logic [15:0] sh [2];
    int          bits [2] = '{0, 0};
    int          fall_cyc [2];
    logic [2:0]  fall_addr [2];
    int          last_rise [2];
    int          min_sp [2] = '{1000, 1000};
    int          max_sp [2] = '{0, 0};
    int          falls [2] = '{0, 0};
    int          discards [2] = '{0, 0};

    logic [15:0] words_a[$], words_b[$];
    logic [2:0]  ad_a[$], ad_b[$];
    int          low_a[$], low_b[$], fc_a[$], fc_b[$], fd_a[$], fd_b[$];

    task automatic mon(input int k, input logic c, input logic n, input logic d,
                       input logic fd, input logic [2:0] a);
        if (prev_ncs[k] && !n) begin
            falls[k]++;
            fall_cyc[k]  = cyc;
            fall_addr[k] = a;
            bits[k]      = 0;
            sh[k]        = '0;
        end
        if (c && !prev_clk[k]) begin
            if (bits[k] > 0) begin
                if (cyc - last_rise[k] < min_sp[k]) min_sp[k] = cyc - last_rise[k];
                if (cyc - last_rise[k] > max_sp[k]) max_sp[k] = cyc - last_rise[k];
            end
            last_rise[k] = cyc;
            sh[k]        = {sh[k][14:0], d};
            bits[k]++;
        end
        if (!prev_ncs[k] && n) begin
            if (bits[k] == 16) begin
                if (k == 0) begin
                    words_a.push_back(sh[k]); low_a.push_back(cyc - fall_cyc[k]);
                    fc_a.push_back(fall_cyc[k]); ad_a.push_back(fall_addr[k]);
                end else begin
                    words_b.push_back(sh[k]); low_b.push_back(cyc - fall_cyc[k]);
                    fc_b.push_back(fall_cyc[k]); ad_b.push_back(fall_addr[k]);
                end
            end else begin
                discards[k]++;
            end
        end
        if (fd) begin
            if (k == 0) fd_a.push_back(cyc);
            else fd_b.push_back(cyc);
        end
        prev_clk[k] = c;
        prev_ncs[k] = n;
    endtask

    always @(negedge clk) if (mon_on) mon(0, bus_a.SC_MAX7219SCAN_CLK_Out,
        bus_a.SC_MAX7219SCAN_NCS_Out, bus_a.SC_MAX7219SCAN_DIN_Out,
        bus_a.SC_MAX7219SCAN_frameDone_Out, bus_a.SC_MAX7219SCAN_addr_OutBUS);
    always @(negedge clk) if (mon_on) mon(1, bus_b.SC_MAX7219SCAN_CLK_Out,
        bus_b.SC_MAX7219SCAN_NCS_Out, bus_b.SC_MAX7219SCAN_DIN_Out,
        bus_b.SC_MAX7219SCAN_frameDone_Out, bus_b.SC_MAX7219SCAN_addr_OutBUS);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    function automatic int nframes(input int k);
        return (k == 0) ? words_a.size() : words_b.size();
    endfunction

    task automatic wait_frames(input int k, input int n, input string name);
        int i = 0;
        while (nframes(k) < n && i < 20000) begin
            @(posedge clk);
            i++;
        end
        check(name, longint'(nframes(k) >= n), 1);
    endtask

    task automatic wait_falls(input int k, input int n, input string name);
        int i = 0;
        while (falls[k] < n && i < 20000) begin
            @(posedge clk);
            i++;
        end
        check(name, longint'(falls[k] >= n), 1);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [2:0]  addr;
    } vec_t;

    vec_t tbl [32];
    int   rel_cyc, rel2_cyc;

    initial begin
        int p;
        int i;
        rst_a = 1'b0; rst_b = 1'b0; int_a = 4'hA;
        ovr_en = 1'b0; ovr_val = 8'hFF; mon_on = 1'b0;

        // Frames 0..26: init, then loops of {intensity, digit1..8}; 27..31: init after reset.
        tbl[0] = '{16'h0C01, 3'd0}; tbl[1] = '{16'h0900, 3'd0};
        tbl[2] = '{16'h0B07, 3'd0}; tbl[3] = '{16'h0F00, 3'd0};
        for (int j = 4; j < 27; j++) begin
            p = (j - 4) % 9;
            if (p == 0) tbl[j] = '{(j < 13) ? 16'h0A0A : 16'h0A03, 3'd0};
            else tbl[j] = '{{4'h0, 4'(p), 8'h80 >> (p - 1)}, 3'(p - 1)};
        end
        tbl[27] = '{16'h0C01, 3'd0}; tbl[28] = '{16'h0900, 3'd0};
        tbl[29] = '{16'h0B07, 3'd0}; tbl[30] = '{16'h0F00, 3'd0};
        tbl[31] = '{16'h0A03, 3'd0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ncs", bus_a.SC_MAX7219SCAN_NCS_Out, 1);
        check("rst_clk", bus_a.SC_MAX7219SCAN_CLK_Out, 0);
        check("rst_din", bus_a.SC_MAX7219SCAN_DIN_Out, 0);
        check("rst_addr", bus_a.SC_MAX7219SCAN_addr_OutBUS, 0);
        check("rst_done", bus_a.SC_MAX7219SCAN_frameDone_Out, 0);
        check("rst_ncs_b", bus_b.SC_MAX7219SCAN_NCS_Out, 1);
        mon_on = 1'b1;
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rel_cyc = cyc;

        // Intensity change while the loop-1 digit-3 frame is shifting.
        wait_falls(0, 8, "wait_digit3");
        repeat (3) @(posedge clk);
        int_a = 4'h3;

        // Data change just after LOAD of a digit-1 frame must not leak in.
        wait_falls(0, 24, "wait_digit1");
        repeat (3) @(posedge clk);
        ovr_en = 1'b1;
        wait_frames(0, 24, "wait_ovr_frame");
        ovr_en = 1'b0;

        // Reset during bit 9 of the digit-5 frame.
        wait_falls(0, 28, "wait_digit5");
        i = 0;
        while (bits[0] < 7 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("reach_bit9", longint'(bits[0] >= 7), 1);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ncs", bus_a.SC_MAX7219SCAN_NCS_Out, 1);
        check("midrst_clk", bus_a.SC_MAX7219SCAN_CLK_Out, 0);
        check("midrst_din", bus_a.SC_MAX7219SCAN_DIN_Out, 0);
        check("midrst_addr", bus_a.SC_MAX7219SCAN_addr_OutBUS, 0);
        repeat (2) @(posedge clk);
        check("midrst_nlatch", words_a.size(), 27);
        check("midrst_discard", discards[0], 1);
        check("done_pulses", fd_a.size(), 2);
        @(negedge clk);
        rst_a = 1'b1; rel2_cyc = cyc;
        wait_frames(0, 32, "wait_reinit");

        for (int k = 0; k < 32; k++) begin
            check($sformatf("a_word[%0d]", k), words_a[k], tbl[k].word);
            check($sformatf("a_addr[%0d]", k), ad_a[k], tbl[k].addr);
            check($sformatf("a_ncs_low[%0d]", k), low_a[k], 133);
            if (k > 0 && k != 27)
                check($sformatf("a_period[%0d]", k), fc_a[k] - fc_a[k-1], 137);
        end
        check("a_first_load", fc_a[0] - rel_cyc, 4);
        check("a_reinit_load", fc_a[27] - rel2_cyc, 4);
        check("a_clk_min", min_sp[0], 8);
        check("a_clk_max", max_sp[0], 8);
        check("a_done_period", fd_a[1] - fd_a[0], 1233);
        check("a_done_align", fd_a[0], fc_a[13]);

        wait_frames(1, 14, "wait_b");
        for (int k = 0; k < 13; k++) begin
            check($sformatf("b_word[%0d]", k), words_b[k], tbl[k].word);
            check($sformatf("b_ncs_low[%0d]", k), low_b[k], 34);
            if (k > 0) check($sformatf("b_period[%0d]", k), fc_b[k] - fc_b[k-1], 35);
        end
        check("b_intensity", words_b[13], 16'h0A0A);
        check("b_first_load", fc_b[0] - rel_cyc, 1);
        check("b_clk_min", min_sp[1], 2);
        check("b_clk_max", max_sp[1], 2);
        check("b_discard", discards[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
